// File: rtl/rf_multiport.sv
// rf_multiport -- parametrised multi-port integer register file with optional
// write-to-read bypass and a per-register busy scoreboard.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active low (0 = reset asserted)
//   RegWrite    per-write-port enable                 [NUM_WR]
//   WriteReg    write addresses, port k at [k*AW +: AW]
//   WriteData   write data, port k at [k*XLEN +: XLEN]
//   ReadReg     read addresses, port i at [i*AW +: AW]
//   ReadData    combinational read data, port i at [i*XLEN +: XLEN]
//   ReadBusy    combinational busy status per read port (after bypass)
//   SetBusy     issue strobe marking SetBusyReg as pending
//   SetBusyReg  destination register of the issuing instruction
//   BusyVec     raw registered busy bits, one per register
module rf_multiport #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_WR-1:0]      RegWrite,
    input  logic [NUM_WR*AW-1:0]   WriteReg,
    input  logic [NUM_WR*XLEN-1:0] WriteData,
    input  logic [NUM_RD*AW-1:0]   ReadReg,
    output logic [NUM_RD*XLEN-1:0] ReadData,
    output logic [NUM_RD-1:0]      ReadBusy,
    input  logic                   SetBusy,
    input  logic [AW-1:0]          SetBusyReg,
    output logic [NREG-1:0]        BusyVec
);

    // Addresses at or above NREG exist only when NREG is not a power of two.
    function automatic logic addr_in_range(input logic [AW-1:0] a);
        return int'(a) < NREG;
    endfunction

    // A register that can be written or marked busy: in range and not the
    // hardwired zero register.
    function automatic logic addr_writable(input logic [AW-1:0] a);
        return addr_in_range(a) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic [AW-1:0]     wr_addr [NUM_WR];
    logic [XLEN-1:0]   wr_data [NUM_WR];
    logic [NUM_WR-1:0] wr_commit;

    logic [AW-1:0]     rd_addr;
    logic [XLEN-1:0]   rd_val;
    logic              rd_busy;

    // Write-port decode. Gating with rst keeps a write strobe during reset
    // from reaching the bypass path as well as the storage.
    always_comb begin
        for (int k = 0; k < NUM_WR; k++) begin
            wr_addr[k]   = WriteReg[k*AW +: AW];
            wr_data[k]   = WriteData[k*XLEN +: XLEN];
            wr_commit[k] = RegWrite[k] && rst && addr_writable(wr_addr[k]);
        end
    end

    // Next state. Ports are applied in ascending order so the highest-index
    // port wins an address conflict; SetBusy is applied last so a new
    // producer keeps the register busy even when an older one commits.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_commit[k]) begin
                regs_d[wr_addr[k]] = wr_data[k];
                busy_d[wr_addr[k]] = 1'b0;
            end
        end
        if (SetBusy && addr_writable(SetBusyReg)) begin
            busy_d[SetBusyReg] = 1'b1;
        end
    end

    // Combinational read ports. The zero register never holds anything but
    // 0 and is never a commit target, so it needs no special case here.
    always_comb begin
        ReadData = '0;
        ReadBusy = '0;
        rd_addr  = '0;
        rd_val   = '0;
        rd_busy  = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr = ReadReg[i*AW +: AW];
            rd_val  = '0;
            rd_busy = 1'b0;
            if (addr_in_range(rd_addr)) begin
                rd_val  = regs_q[rd_addr];
                rd_busy = busy_q[rd_addr];
            end
            if (BYPASS != 0) begin
                // Ascending scan: the last match is the highest-index port.
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_commit[k] && (wr_addr[k] == rd_addr)) begin
                        rd_val  = wr_data[k];
                        rd_busy = 1'b0;
                    end
                end
            end
            ReadData[i*XLEN +: XLEN] = rd_val;
            ReadBusy[i]              = rd_busy;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign BusyVec = busy_q;

endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport -- self-checking bench for rf_multiport. Two instances share
// one stimulus stream: dut_a (NREG=32, BYPASS=1, ZERO_REG=1) and dut_b
// (NREG=24, BYPASS=0, ZERO_REG=0), both with two read and two write ports.
module tb_rf_multiport;

    logic        clk;
    logic        rst;
    logic [1:0]  we;
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic [4:0]  ra [2];
    logic        sb;
    logic [4:0]  sbr;

    logic [9:0]  wreg_p;
    logic [63:0] wdata_p;
    logic [9:0]  rreg_p;
    logic [63:0] rdata_a, rdata_b;
    logic [1:0]  rbusy_a, rbusy_b;
    logic [31:0] bvec_a;
    logic [23:0] bvec_b;

    int total = 0;
    int bad   = 0;

    assign wreg_p  = {wa[1], wa[0]};
    assign wdata_p = {wd[1], wd[0]};
    assign rreg_p  = {ra[1], ra[0]};

    rf_multiport #(.XLEN(32), .NREG(32), .NUM_RD(2), .NUM_WR(2),
                   .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .RegWrite(we), .WriteReg(wreg_p),
        .WriteData(wdata_p), .ReadReg(rreg_p), .ReadData(rdata_a),
        .ReadBusy(rbusy_a), .SetBusy(sb), .SetBusyReg(sbr), .BusyVec(bvec_a));

    rf_multiport #(.XLEN(32), .NREG(24), .NUM_RD(2), .NUM_WR(2),
                   .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .RegWrite(we), .WriteReg(wreg_p),
        .WriteData(wdata_p), .ReadReg(rreg_p), .ReadData(rdata_b),
        .ReadBusy(rbusy_b), .SetBusy(sb), .SetBusyReg(sbr), .BusyVec(bvec_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural contents and busy flags per instance.
    logic [31:0] m_reg  [2][32];
    bit          m_busy [2][32];
    int          nr  [2] = '{32, 24};
    bit          byp [2] = '{1'b1, 1'b0};
    bit          zr  [2] = '{1'b1, 1'b0};

    task automatic chk_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic bit target_ok(int d, int a);
        return (a < nr[d]) && !(zr[d] && a == 0);
    endfunction

    // Index of the highest write port hitting address a this cycle, or -1.
    function automatic int live_writer(int d, int a);
        int w = -1;
        if (rst) begin
            for (int k = 0; k < 2; k++)
                if (we[k] && int'(wa[k]) == a && target_ok(d, a)) w = k;
        end
        return w;
    endfunction

    function automatic logic [31:0] exp_rd(int d, int a);
        if (a >= nr[d] || (zr[d] && a == 0)) return 32'h0;
        if (byp[d] && live_writer(d, a) >= 0) return wd[live_writer(d, a)];
        return m_reg[d][a];
    endfunction

    function automatic bit exp_rbusy(int d, int a);
        if (a >= nr[d]) return 1'b0;
        if (byp[d] && live_writer(d, a) >= 0) return 1'b0;
        return m_busy[d][a];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 32; r++) begin
                m_reg[d][r]  = 32'h0;
                m_busy[d][r] = 1'b0;
            end
    endtask

    task automatic model_commit();
        int w;
        bit newb;
        if (!rst) return;
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < nr[d]; r++) begin
                w = live_writer(d, r);
                newb = m_busy[d][r];
                if (w >= 0) begin
                    m_reg[d][r] = wd[w];
                    newb = 1'b0;
                end
                if (sb && int'(sbr) == r && target_ok(d, r)) newb = 1'b1;
                m_busy[d][r] = newb;
            end
    endtask

    task automatic check_all(input string ph);
        logic [31:0] got;
        logic [31:0] bv_got, bv_exp;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 2; i++) begin
                got = (d == 0) ? rdata_a[i*32 +: 32] : rdata_b[i*32 +: 32];
                chk_val($sformatf("%s dut%0d rdata%0d x%0d", ph, d, i, ra[i]),
                        64'(got), 64'(exp_rd(d, int'(ra[i]))));
                chk_val($sformatf("%s dut%0d rbusy%0d x%0d", ph, d, i, ra[i]),
                        64'((d == 0) ? rbusy_a[i] : rbusy_b[i]),
                        64'(exp_rbusy(d, int'(ra[i]))));
            end
            bv_got = (d == 0) ? bvec_a : {8'h0, bvec_b};
            bv_exp = '0;
            for (int r = 0; r < nr[d]; r++) bv_exp[r] = m_busy[d][r];
            chk_val($sformatf("%s dut%0d busyvec", ph, d), 64'(bv_got), 64'(bv_exp));
        end
    endtask

    task automatic set_idle();
        we = 2'b00; sb = 1'b0; sbr = 5'd0;
        for (int k = 0; k < 2; k++) begin
            wa[k] = 5'd0; wd[k] = 32'h0; ra[k] = 5'd0;
        end
    endtask

    // Inputs are already applied; check the combinational view, clock, update model.
    task automatic do_cycle(input string ph);
        #1;
        check_all(ph);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic wr1(input int k, input int a, input logic [31:0] v);
        we[k] = 1'b1; wa[k] = 5'(a); wd[k] = v;
    endtask

    int pool [6] = '{3, 5, 9, 0, 23, 29};

    initial begin
        set_idle();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        ra[0] = 5'd5;
        check_all("in_reset");
        #2 rst = 1'b1;

        // Reset, then write/read
        set_idle(); wr1(0, 5, 32'hAABBCCDD);  do_cycle("w5");
        set_idle(); wr1(0, 10, 32'h12345678); do_cycle("w10");
        set_idle(); ra[0] = 5'd10; ra[1] = 5'd5;
        #1;
        chk_val("t1 a rd0", 64'(rdata_a[31:0]),  64'h12345678);
        chk_val("t1 a rd1", 64'(rdata_a[63:32]), 64'hAABBCCDD);
        chk_val("t1 busyvec", 64'(bvec_a), 64'h0);
        do_cycle("rd10_5");

        // Register 0: hardwired in dut_a, ordinary in dut_b
        set_idle(); wr1(0, 0, 32'hFFFFFFFF); sb = 1'b1; sbr = 5'd0;
        do_cycle("w0");
        set_idle(); ra[0] = 5'd0;
        #1;
        chk_val("x0 a rd", 64'(rdata_a[31:0]), 64'h0);
        chk_val("x0 a rbusy", 64'(rbusy_a[0]), 64'h0);
        chk_val("x0 a bvec0", 64'(bvec_a[0]), 64'h0);
        chk_val("x0 b rd", 64'(rdata_b[31:0]), 64'hFFFFFFFF);
        chk_val("x0 b bvec0", 64'(bvec_b[0]), 64'h1);
        do_cycle("rd0");

        // Bypass vs. stored-only reads
        set_idle(); wr1(0, 7, 32'h11111111); do_cycle("w7a");
        set_idle(); wr1(0, 7, 32'h22222222); ra[0] = 5'd7;
        #1;
        chk_val("byp a pre", 64'(rdata_a[31:0]), 64'h22222222);
        chk_val("byp b pre", 64'(rdata_b[31:0]), 64'h11111111);
        do_cycle("w7b");
        set_idle(); ra[0] = 5'd7;
        #1;
        chk_val("byp b post", 64'(rdata_b[31:0]), 64'h22222222);
        do_cycle("rd7");

        // Dual-write conflict and dual distinct writes
        set_idle(); wr1(0, 3, 32'hAAAA0000); wr1(1, 3, 32'hBBBB0000);
        ra[0] = 5'd3; do_cycle("conf");
        set_idle(); ra[0] = 5'd3;
        #1;
        chk_val("conf a x3", 64'(rdata_a[31:0]), 64'hBBBB0000);
        chk_val("conf b x3", 64'(rdata_b[31:0]), 64'hBBBB0000);
        do_cycle("rd3");
        set_idle(); wr1(0, 3, 32'h33333333); wr1(1, 4, 32'h44444444); do_cycle("w34");
        set_idle(); ra[0] = 5'd3; ra[1] = 5'd4;
        #1;
        chk_val("dual a x3", 64'(rdata_a[31:0]),  64'h33333333);
        chk_val("dual a x4", 64'(rdata_a[63:32]), 64'h44444444);
        do_cycle("rd34");

        // Scoreboard
        set_idle(); sb = 1'b1; sbr = 5'd9; do_cycle("sb9");
        set_idle(); ra[0] = 5'd9;
        #1;
        chk_val("sb a bvec9", 64'(bvec_a[9]), 64'h1);
        chk_val("sb a rbusy", 64'(rbusy_a[0]), 64'h1);
        wr1(0, 9, 32'h99999999);
        #1;
        chk_val("sb a rbusy wr", 64'(rbusy_a[0]), 64'h0);
        chk_val("sb b rbusy wr", 64'(rbusy_b[0]), 64'h1);
        do_cycle("w9");
        set_idle(); ra[0] = 5'd9;
        #1;
        chk_val("sb a bvec9 clr", 64'(bvec_a[9]), 64'h0);
        wr1(0, 9, 32'h9999AAAA); sb = 1'b1; sbr = 5'd9;
        do_cycle("sbw9");
        set_idle();
        #1;
        chk_val("sb a bvec9 keep", 64'(bvec_a[9]), 64'h1);
        chk_val("sb b bvec9 keep", 64'(bvec_b[9]), 64'h1);

        // Illegal addresses on dut_b (NREG=24)
        wr1(0, 28, 32'h28282828); sb = 1'b1; sbr = 5'd28; ra[0] = 5'd28;
        do_cycle("ill");
        set_idle(); ra[0] = 5'd28;
        #1;
        chk_val("ill b rd", 64'(rdata_b[31:0]), 64'h0);
        chk_val("ill a rd", 64'(rdata_a[31:0]), 64'h28282828);
        do_cycle("rd28");

        // Asynchronous reset mid-operation
        set_idle(); wr1(0, 12, 32'hCAFEF00D); do_cycle("w12");
        set_idle(); sb = 1'b1; sbr = 5'd12; do_cycle("sb12");
        set_idle(); ra[0] = 5'd12;
        #1;
        chk_val("ar pre rd", 64'(rdata_a[31:0]), 64'hCAFEF00D);
        chk_val("ar pre bvec12", 64'(bvec_a[12]), 64'h1);
        rst = 1'b0;
        model_reset();
        #1;
        chk_val("ar a rd", 64'(rdata_a[31:0]), 64'h0);
        chk_val("ar a bvec", 64'(bvec_a), 64'h0);
        chk_val("ar b bvec", 64'(bvec_b), 64'h0);
        wr1(0, 12, 32'hDEADBEEF);
        #1;
        chk_val("ar a rd wr", 64'(rdata_a[31:0]), 64'h0);
        @(posedge clk);
        model_commit();
        #1;
        check_all("ar_hold");
        set_idle(); ra[0] = 5'd12;
        #1 rst = 1'b1;
        #1;
        chk_val("ar rel a rd", 64'(rdata_a[31:0]), 64'h0);
        chk_val("ar rel b rd", 64'(rdata_b[31:0]), 64'h0);
        do_cycle("ar_rel");

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                we[k] = 1'($urandom);
                wa[k] = ($urandom_range(0, 3) != 0) ? 5'(pool[$urandom_range(0, 5)])
                                                     : 5'($urandom_range(0, 31));
                wd[k] = $urandom;
                ra[k] = ($urandom_range(0, 2) == 0) ? wa[$urandom_range(0, 1)]
                                                    : 5'(pool[$urandom_range(0, 5)]);
            end
            sb  = ($urandom_range(0, 2) == 0);
            sbr = ($urandom_range(0, 1) == 0) ? 5'(pool[$urandom_range(0, 5)])
                                              : 5'($urandom_range(0, 31));
            do_cycle("rnd");
        end
        set_idle();
        do_cycle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
- Parametrised successor to the single-write, two-read RISC-V integer register file.
- Configurable register width, register count, read-port count and write-port count.
- Adds optional write-to-read bypass and a per-register busy scoreboard for in-order issue/writeback.
- Sits between decode (read and issue side) and writeback (write side) of the RISCV_processor core.

Parameters:
- XLEN, 32, register data width in bits.
- NREG, 32, number of architectural registers; must be ≥2.
- NUM_RD, 2, number of read ports.
- NUM_WR, 1, number of write ports; legal range 1–4.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads; 0 = reads see only stored state.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero.
- Local AW = clog2(NREG), register address width.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous active-low reset (0 = reset asserted).
- RegWrite, in, NUM_WR, per-port write enable.
- WriteReg, in, NUM_WR*AW, write addresses; port k occupies bits [k*AW +: AW].
- WriteData, in, NUM_WR*XLEN, write data; port k occupies bits [k*XLEN +: XLEN].
- ReadReg, in, NUM_RD*AW, read addresses; port i occupies bits [i*AW +: AW].
- ReadData, out, NUM_RD*XLEN, read data; combinational.
- ReadBusy, out, NUM_RD, busy status of each read address after bypass; combinational.
- SetBusy, in, 1, issue strobe that marks SetBusyReg as pending.
- SetBusyReg, in, AW, destination register of the issuing instruction.
- BusyVec, out, NREG, registered busy bits, one per register.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers clear to 0 and all busy bits clear to 0 immediately, mid-cycle included.
  - Writes and SetBusy are ignored while rst=0.
  - First update takes effect at the first rising edge after rst returns to 1.
- Write timing: at posedge clk, each port k with RegWrite[k]=1 and a legal address stores WriteData[k].
- Write conflict: several enabled ports with the same address → highest-index port wins.
- Illegal address: any address ≥ NREG (NREG not a power of two):
  - Writes are dropped.
  - Reads return 0 and ReadBusy=0.
  - SetBusy is ignored.
- Reads: purely combinational, zero-cycle latency.
  - BYPASS=1: if any port has RegWrite[k]=1 and WriteReg[k]==ReadReg[i], ReadData[i] = WriteData of the highest-index matching port; otherwise the stored value.
  - BYPASS=0: ReadData[i] is always the stored value; the old value is visible until the edge.
- ZERO_REG=1 and address 0:
  - Writes are dropped; reads return 0, bypass included.
  - Never busy; SetBusy to register 0 is ignored.
- ZERO_REG=0: register 0 behaves like any other register.
- Scoreboard, evaluated at posedge:
  - busy[r] sets when SetBusy=1 and SetBusyReg=r.
  - busy[r] clears when any write port commits to r.
  - SetBusy and a commit to the same r in the same cycle → busy stays 1 (new producer wins).
  - Otherwise busy[r] holds.
- ReadBusy[i]:
  - Base value is busy[ReadReg[i]].
  - BYPASS=1: forced to 0 when a same-cycle write matches ReadReg[i], since the data is available now.
  - BYPASS=0: no same-cycle override.
- BusyVec: always the raw registered busy bits, with no bypass masking.

Test Plan:
- Reset then write/read:
  - rst=0 for 2 cycles, release; write x5=AABBCCDD, then x10=12345678.
  - Next cycle ReadReg={10,5} → ReadData={12345678,AABBCCDD}; BusyVec=0.
- x0 hardwired (ZERO_REG=1): write x0=FFFFFFFF; SetBusy to x0.
  - Read x0 → 00000000, ReadBusy=0, BusyVec[0]=0.
- Bypass (BYPASS=1): with x7=11111111 stored, same cycle RegWrite=1, WriteReg=7, WriteData=22222222, ReadReg0=7.
  - ReadData0=22222222 before the edge.
  - With BYPASS=0, the same stimulus reads 11111111 before the edge and 22222222 after it.
- Dual-write conflict (NUM_WR=2): both ports write x3, port0=AAAA0000, port1=BBBB0000.
  - Next cycle x3 reads BBBB0000.
  - Different addresses x3/x4 in one cycle → both stored.
- Scoreboard: SetBusy x9 → BusyVec[9]=1 after the edge and ReadBusy=1 on a read of x9.
  - Write x9 → ReadBusy=0 during the write cycle; BusyVec[9]=0 after the edge.
  - SetBusy x9 together with a write to x9 → BusyVec[9] stays 1.
- Async reset mid-operation: x12=CAFEF00D stored and busy[12]=1; drop rst between edges.
  - ReadData=0 and BusyVec=0 immediately.
  - A RegWrite pulse during reset is ignored.
  - After release, x12 still reads 0.
